audio_dma_responder: RTL and testbench

- Memory-side responder for the audio channel DMA fetch interface (req/ack/tile/addr/word).
- Accepts one word-read request at a time from the audio mixer and routes it to VRAM or tile memory.
- Issues each read only in cycles where the higher-priority user (video/blitter) leaves that memory idle.
- Returns the 16-bit word with a single-cycle ack; sits between the audio mixer and the VRAM/TILEMEM arbitration muxes.

---
 rtl/audio_dma_responder_if.sv | 25 ++
 rtl/audio_dma_responder.sv | 109 ++++++++++
 tb/tb_audio_dma_responder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/audio_dma_responder_if.sv
// Audio DMA fetch bus: the mixer raises req with tile/addr held,
// the responder answers with a one-cycle ack and the fetched word.
interface audio_dma_if;
    logic        req;
    logic        tile;
    logic [15:0] addr;
    logic        ack;
    logic [15:0] word;

    modport master (
        output req,
        output tile,
        output addr,
        input  ack,
        input  word
    );

    modport slave (
        input  req,
        input  tile,
        input  addr,
        output ack,
        output word
    );
endinterface

// File: rtl/audio_dma_responder.sv
// Audio DMA responder: steals idle VRAM/tile-memory cycles for mixer reads.
// Optional starvation flag enabled by defining AUDIO_DMA_STARVE_EN.
module audio_dma_responder #(
    parameter int TILE_AW      = 12,
    parameter int STARVE_LIMIT = 64
) (
    input  logic               clk,
    input  logic               reset_ni,
    audio_dma_if.slave         audio,
    input  logic               vram_busy_i,
    output logic               vram_sel_o,
    output logic [15:0]        vram_addr_o,
    input  logic [15:0]        vram_data_i,
    input  logic               tile_busy_i,
    output logic               tile_sel_o,
    output logic [TILE_AW-1:0] tile_addr_o,
    input  logic [15:0]        tile_data_i,
    output logic               audio_urgent_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]  r_state;
    logic        r_tile;
    logic [15:0] r_addr;
    logic        r_ack;
    logic [15:0] r_word;

    logic w_wait;
    logic w_busy;
    logic w_issue;

    assign w_wait  = (r_state == S_WAIT);
    assign w_busy  = r_tile ? tile_busy_i : vram_busy_i;
    assign w_issue = w_wait & ~w_busy;

    assign vram_sel_o  = w_issue & ~r_tile;
    assign tile_sel_o  = w_issue & r_tile;
    assign vram_addr_o = r_addr;
    assign tile_addr_o = r_addr[TILE_AW-1:0];

    assign audio.ack  = r_ack;
    assign audio.word = r_word;

    // ack masks req: the requester only drops req on the edge that sees ack
    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            r_state <= S_IDLE;
            r_tile  <= 1'b0;
            r_addr  <= 16'h0000;
            r_ack   <= 1'b0;
            r_word  <= 16'h0000;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (audio.req && !r_ack) begin
                        r_tile  <= audio.tile;
                        r_addr  <= audio.addr;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_issue)
                        r_state <= S_DATA;
                    else if (!audio.req)
                        r_state <= S_IDLE;
                end
                S_DATA: begin
                    r_word  <= r_tile ? tile_data_i : vram_data_i;
                    r_ack   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef AUDIO_DMA_STARVE_EN
    localparam logic [7:0] LIM_M1 = 8'(STARVE_LIMIT - 1);

    logic [7:0] r_cnt;
    logic       r_urgent;
    logic [7:0] w_cnt_nxt;

    assign w_cnt_nxt      = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    assign audio_urgent_o = r_urgent;

    // only a busy cycle that stays in WAIT keeps the count alive
    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            r_cnt    <= 8'h00;
            r_urgent <= 1'b0;
        end else if (w_wait && w_busy && audio.req) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt >= LIM_M1)
                r_urgent <= 1'b1;
        end else begin
            r_cnt    <= 8'h00;
            r_urgent <= 1'b0;
        end
    end
`else
    assign audio_urgent_o = 1'b0;
`endif

endmodule

// File: tb/tb_audio_dma_responder.sv
// Directed bench for audio_dma_responder.
// Starvation checks follow AUDIO_DMA_STARVE_EN when defined.
module tb_audio_dma_responder;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        vram_busy_i;
    logic        vram_sel_o;
    logic [15:0] vram_addr_o;
    logic [15:0] vram_data_i;
    logic        tile_busy_i;
    logic        tile_sel_o;
    logic [11:0] tile_addr_o;
    logic [15:0] tile_data_i;
    logic        audio_urgent_o;

    logic [15:0] vdat;
    logic [15:0] tdat;

    int n_chk  = 0;
    int n_pass = 0;
    int n_ack  = 0;
    int n_vsel = 0;
    int n_tsel = 0;

    audio_dma_if bus ();

    audio_dma_responder #(
        .TILE_AW(12),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset_ni(reset_ni),
        .audio(bus),
        .vram_busy_i(vram_busy_i),
        .vram_sel_o(vram_sel_o),
        .vram_addr_o(vram_addr_o),
        .vram_data_i(vram_data_i),
        .tile_busy_i(tile_busy_i),
        .tile_sel_o(tile_sel_o),
        .tile_addr_o(tile_addr_o),
        .tile_data_i(tile_data_i),
        .audio_urgent_o(audio_urgent_o)
    );

    always #5 clk = ~clk;

    // memories return data one cycle after select, junk otherwise
    always @(posedge clk) begin
        vram_data_i <= vram_sel_o ? vdat : 16'hDEAD;
        tile_data_i <= tile_sel_o ? tdat : 16'hDEAD;
        if (bus.ack)    n_ack++;
        if (vram_sel_o) n_vsel++;
        if (tile_sel_o) n_tsel++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        n_ack  = 0;
        n_vsel = 0;
        n_tsel = 0;
    endtask

    task automatic run_busy(input int n);
        logic exp_u;
        vdat = 16'h0A00 + 16'(n);
        clr();
        bus.req = 1'b1;
        bus.tile = 1'b0;
        bus.addr = 16'h0042;
        vram_busy_i = 1'b1;
        tick();
        for (int i = 1; i <= n; i++) begin
            exp_u = 1'b0;
`ifdef AUDIO_DMA_STARVE_EN
            exp_u = (i >= 4);
`endif
            chk("busy_sel", {31'd0, vram_sel_o}, 32'd0);
            chk("busy_urg", {31'd0, audio_urgent_o}, {31'd0, exp_u});
            tick();
        end
        vram_busy_i = 1'b0;
        #1;
        exp_u = 1'b0;
`ifdef AUDIO_DMA_STARVE_EN
        exp_u = (n >= 3);
`endif
        chk("busy_sel_go", {31'd0, vram_sel_o}, 32'd1);
        chk("busy_urg_sel", {31'd0, audio_urgent_o}, {31'd0, exp_u});
        tick();
        chk("busy_ack_early", {31'd0, bus.ack}, 32'd0);
        chk("busy_urg_clr", {31'd0, audio_urgent_o}, 32'd0);
        tick();
        chk("busy_ack", {31'd0, bus.ack}, 32'd1);
        chk("busy_word", {16'd0, bus.word}, {16'd0, vdat});
        tick();
        bus.req = 1'b0;
        tick();
        tick();
        chk("busy_nack", n_ack, 1);
        chk("busy_nsel", n_vsel, 1);
    endtask

    initial begin
        reset_ni = 1'b0;
        bus.req = 1'b0;
        bus.tile = 1'b0;
        bus.addr = 16'h0000;
        vram_busy_i = 1'b0;
        tile_busy_i = 1'b0;
        vdat = 16'h0000;
        tdat = 16'h0000;
        tick();
        tick();
        chk("rst_ack", {31'd0, bus.ack}, 32'd0);
        chk("rst_word", {16'd0, bus.word}, 32'd0);
        chk("rst_urg", {31'd0, audio_urgent_o}, 32'd0);
        chk("rst_vaddr", {16'd0, vram_addr_o}, 32'd0);
        chk("rst_vsel", {31'd0, vram_sel_o}, 32'd0);
        reset_ni = 1'b1;
        tick();

        // VRAM read, req held through the ack cycle
        vdat = 16'hBEEF;
        clr();
        bus.req = 1'b1;
        bus.tile = 1'b0;
        bus.addr = 16'h1234;
        tick();
        chk("v_sel", {31'd0, vram_sel_o}, 32'd1);
        chk("v_addr", {16'd0, vram_addr_o}, 32'h1234);
        chk("v_tsel", {31'd0, tile_sel_o}, 32'd0);
        bus.addr = 16'h5555;
        tick();
        chk("v_addr_hold", {16'd0, vram_addr_o}, 32'h1234);
        chk("v_ack_early", {31'd0, bus.ack}, 32'd0);
        tick();
        chk("v_ack", {31'd0, bus.ack}, 32'd1);
        chk("v_word", {16'd0, bus.word}, 32'hBEEF);
        tick();
        bus.req = 1'b0;
        chk("v_ack_one", {31'd0, bus.ack}, 32'd0);
        chk("v_sel_after", {31'd0, vram_sel_o}, 32'd0);
        tick();
        tick();
        tick();
        chk("v_nsel", n_vsel, 1);
        chk("v_ntsel", n_tsel, 0);
        chk("v_nack", n_ack, 1);
        chk("v_word_hold", {16'd0, bus.word}, 32'hBEEF);

        // tile read with address truncation
        tdat = 16'h1357;
        clr();
        bus.req = 1'b1;
        bus.tile = 1'b1;
        bus.addr = 16'hF7A5;
        tick();
        chk("t_sel", {31'd0, tile_sel_o}, 32'd1);
        chk("t_addr", {20'd0, tile_addr_o}, 32'h07A5);
        chk("t_vsel", {31'd0, vram_sel_o}, 32'd0);
        tick();
        tick();
        chk("t_ack", {31'd0, bus.ack}, 32'd1);
        chk("t_word", {16'd0, bus.word}, 32'h1357);
        tick();
        bus.req = 1'b0;
        tick();
        tick();
        chk("t_nvsel", n_vsel, 0);
        chk("t_ntsel", n_tsel, 1);
        chk("t_nack", n_ack, 1);

        run_busy(5);
        run_busy(10);

        // abort while VRAM stays busy
        clr();
        bus.req = 1'b1;
        bus.tile = 1'b0;
        bus.addr = 16'h0100;
        vram_busy_i = 1'b1;
        tick();
        tick();
        bus.req = 1'b0;
        chk("ab_sel", {31'd0, vram_sel_o}, 32'd0);
        tick();
        vram_busy_i = 1'b0;
        tick();
        tick();
        tick();
        chk("ab_nsel", n_vsel, 0);
        chk("ab_nack", n_ack, 0);
        chk("ab_urg", {31'd0, audio_urgent_o}, 32'd0);
        chk("ab_word", {16'd0, bus.word}, 32'h0A0A);

        // reset while in DATA
        vdat = 16'h7777;
        clr();
        bus.req = 1'b1;
        bus.addr = 16'h0200;
        tick();
        chk("rd_sel", {31'd0, vram_sel_o}, 32'd1);
        tick();
        reset_ni = 1'b0;
        bus.req = 1'b0;
        tick();
        chk("rd_ack", {31'd0, bus.ack}, 32'd0);
        chk("rd_word", {16'd0, bus.word}, 32'd0);
        chk("rd_vaddr", {16'd0, vram_addr_o}, 32'd0);
        reset_ni = 1'b1;
        tick();
        tick();
        chk("rd_nack", n_ack, 0);
        chk("rd_word_hold", {16'd0, bus.word}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
